// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Optional result clamping is compiled in with `define CSEL_SAT_EN (adds input sat).
module csel_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
`ifdef CSEL_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = (BLK > 0) ? (WIDTH / BLK) : 1;

  if (BLK < 1 || (WIDTH % BLK) != 0) begin : g_param_check
    $error("csel_adder_pipe: WIDTH (%0d) must be a positive multiple of BLK (%0d)", WIDTH, BLK);
  end

  logic s1_valid;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s2_adv || !s1_valid;
  assign in_ready = s1_adv;

  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff = op ? ~b : b;
  assign c0    = op ? ~cin : cin;

  logic [BLK-1:0] s0_d  [NBLK];
  logic [BLK-1:0] s1_d  [NBLK];
  logic           co0_d [NBLK];
  logic           co1_d [NBLK];

  // Block 0 folds c0 in directly, so both of its candidate pairs carry the real result.
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic [BLK:0] p0;
    logic [BLK:0] p1;
    if (k == 0) begin : g_first
      assign p0 = {1'b0, a[0 +: BLK]} + {1'b0, b_eff[0 +: BLK]} + {{BLK{1'b0}}, c0};
      assign p1 = p0;
    end else begin : g_rest
      assign p0 = {1'b0, a[k*BLK +: BLK]} + {1'b0, b_eff[k*BLK +: BLK]};
      assign p1 = {1'b0, a[k*BLK +: BLK]} + {1'b0, b_eff[k*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
    end
    assign s0_d[k]  = p0[BLK-1:0];
    assign co0_d[k] = p0[BLK];
    assign s1_d[k]  = p1[BLK-1:0];
    assign co1_d[k] = p1[BLK];
  end

  logic [BLK-1:0] s0_q  [NBLK];
  logic [BLK-1:0] s1_q  [NBLK];
  logic           co0_q [NBLK];
  logic           co1_q [NBLK];
  logic           c0_q;
  logic           a_msb_q;
  logic           b_msb_q;
`ifdef CSEL_SAT_EN
  logic           op_q;
  logic           sat_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      c0_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
`ifdef CSEL_SAT_EN
      op_q     <= 1'b0;
      sat_q    <= 1'b0;
`endif
      for (int k = 0; k < NBLK; k++) begin
        s0_q[k]  <= '0;
        s1_q[k]  <= '0;
        co0_q[k] <= 1'b0;
        co1_q[k] <= 1'b0;
      end
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        c0_q    <= c0;
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b_eff[WIDTH-1];
`ifdef CSEL_SAT_EN
        op_q    <= op;
        sat_q   <= sat;
`endif
        for (int k = 0; k < NBLK; k++) begin
          s0_q[k]  <= s0_d[k];
          s1_q[k]  <= s1_d[k];
          co0_q[k] <= co0_d[k];
          co1_q[k] <= co1_d[k];
        end
      end
    end
  end

  logic [NBLK:0]    c_chain;
  logic [WIDTH-1:0] sel_sum;
  logic [WIDTH-1:0] res_sum;
  logic             sel_cout;
  logic             sel_ovf;

  always_comb begin
    c_chain = '0;
    sel_sum = '0;
    c_chain[0] = c0_q;
    for (int k = 0; k < NBLK; k++) begin
      sel_sum[k*BLK +: BLK] = c_chain[k] ? s1_q[k] : s0_q[k];
      c_chain[k+1]          = c_chain[k] ? co1_q[k] : co0_q[k];
    end
    sel_cout = c_chain[NBLK];
    sel_ovf  = (a_msb_q == b_msb_q) && (sel_sum[WIDTH-1] != a_msb_q);
    res_sum  = sel_sum;
`ifdef CSEL_SAT_EN
    // Clamp is unsigned only; cout/ovf keep reporting the raw condition.
    if (sat_q) begin
      if (!op_q && sel_cout) begin
        res_sum = '1;
      end else if (op_q && !sel_cout) begin
        res_sum = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= res_sum;
        cout <= sel_cout;
        ovf  <= sel_ovf;
      end
    end
  end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench for csel_adder_pipe (WIDTH=8, BLK=4); covers CSEL_SAT_EN when defined.
module tb_csel_adder_pipe;
  localparam int W   = 8;
  localparam int BLK = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op = 1'b0;
  logic         sat = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  logic [W+1:0] exp_q [$];
  logic [W+1:0] obs_q [$];

  logic [W-1:0] st_a [$];
  logic [W-1:0] st_b [$];
  logic         st_cin [$];
  logic         st_op [$];
  logic         st_sat [$];

  int stalled_in = 0;

  csel_adder_pipe #(.WIDTH(W), .BLK(BLK)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .op(op),
`ifdef CSEL_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, signed range check for overflow.
  function automatic logic [W+1:0] model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                         input logic vc, input logic vop, input logic vsat);
    logic [W:0]   r;
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           si;
    if (!vop) begin
      r  = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
      c  = r[W];
      si = int'($signed(va)) + int'($signed(vb)) + int'(vc);
    end else begin
      r  = {1'b0, va} - {1'b0, vb} - {{W{1'b0}}, vc};
      c  = ~r[W];
      si = int'($signed(va)) - int'($signed(vb)) - int'(vc);
    end
    v = (si > (2**(W-1)) - 1) || (si < -(2**(W-1)));
    s = r[W-1:0];
`ifdef CSEL_SAT_EN
    if (vsat && !vop && c) s = '1;
    if (vsat && vop && !c) s = '0;
`else
    if (vsat) s = r[W-1:0];
`endif
    return {s, c, v};
  endfunction

  // Monitor: pop on output transfer, push on input transfer (both occur at the coming posedge).
  always @(negedge clk) begin
    logic [W+1:0] e;
    #2;
    if (!rst) begin
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output got sum=%h cout=%b ovf=%b with empty scoreboard", sum, cout, ovf);
        end else begin
          e = exp_q.pop_front();
          if ({sum, cout, ovf} !== e) begin
            bad++;
            $display("FAIL scoreboard got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     sum, cout, ovf, e[W+1:2], e[1], e[0]);
          end
        end
        obs_q.push_back({sum, cout, ovf});
        pops++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, op, sat));
    end
  end

  task automatic add_vec(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, input logic vop, input logic vsat);
    st_a.push_back(va); st_b.push_back(vb); st_cin.push_back(vc);
    st_op.push_back(vop); st_sat.push_back(vsat);
  endtask

  task automatic clear_vecs();
    st_a.delete(); st_b.delete(); st_cin.delete(); st_op.delete(); st_sat.delete();
    obs_q.delete();
  endtask

  // Streams the queued vectors; returns the cycle index of the last output transfer (-1 on timeout).
  task automatic run_stream(input int stall_start, input int stall_len, input bit rnd,
                            output int last);
    int n = st_a.size();
    int idx = 0;
    int p0 = pops;
    bit have_hold = 0;
    logic [W-1:0] hold_sum = '0;
    last = -1;
    stalled_in = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else     out_ready = !(c >= stall_start && c < stall_start + stall_len);
      if (idx < n && !(rnd && $urandom_range(0, 4) == 0)) begin
        in_valid = 1'b1;
        a = st_a[idx]; b = st_b[idx]; cin = st_cin[idx]; op = st_op[idx]; sat = st_sat[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) stalled_in++;
      if (!rnd && !out_ready && out_valid) begin
        if (have_hold) begin
          total++;
          if (sum !== hold_sum) begin
            bad++;
            $display("FAIL hold_stable cycle=%0d got sum=%h want %h", c, sum, hold_sum);
          end
        end
        hold_sum  = sum;
        have_hold = 1;
      end
      if (in_valid && in_ready) idx++;
      #2;
      if (pops - p0 == n) begin
        last = c;
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (last < 0) begin
      bad++;
      $display("FAIL stream_timeout got %0d results want %0d", pops - p0, n);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({out_valid, sum, cout, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b sum=%h cout=%b ovf=%b want all 0", out_valid, sum, cout, ovf);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0; op = 1'b0; sat = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL lat_accept got in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL lat_early got out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || sum !== 8'h10 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL lat_result got valid=%b sum=%h cout=%b ovf=%b want 1 10 0 0", out_valid, sum, cout, ovf);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_add();
    logic [W+1:0] want [4] = '{{8'h10, 1'b0, 1'b0}, {8'h00, 1'b1, 1'b0},
                               {8'h80, 1'b0, 1'b1}, {8'h03, 1'b0, 1'b0}};
    int last;
    clear_vecs();
    add_vec(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    add_vec(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    add_vec(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    add_vec(8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
    run_stream(0, 0, 1'b0, last);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== want[i]) begin
        bad++;
        $display("FAIL add_vec%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, want[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [W+1:0] want [3] = '{{8'hFE, 1'b0, 1'b0}, {8'h7F, 1'b1, 1'b1}, {8'h0F, 1'b1, 1'b0}};
    int last;
    clear_vecs();
    add_vec(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    add_vec(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    add_vec(8'h10, 8'h00, 1'b1, 1'b1, 1'b0);
    run_stream(0, 0, 1'b0, last);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== want[i]) begin
        bad++;
        $display("FAIL sub_vec%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int last;
    clear_vecs();
    for (int i = 0; i < 5; i++) add_vec(W'(8'h11 * (i + 1)), W'(8'h2C + i), 1'(i & 1), 1'(i > 2), 1'b0);
    run_stream(2, 3, 1'b0, last);
    total++;
    if (stalled_in == 0) begin
      bad++;
      $display("FAIL bp_in_ready got stalled cycles=%0d want >0", stalled_in);
    end
    total++;
    if (last != 5 + 1 + 3) begin
      bad++;
      $display("FAIL bp_throughput got last cycle=%0d want %0d", last, 9);
    end
  endtask

  task automatic test_back_to_back();
    int last;
    clear_vecs();
    for (int i = 0; i < 8; i++) add_vec(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    run_stream(0, 0, 1'b0, last);
    total++;
    if (last != 8 + 1 || stalled_in != 0) begin
      bad++;
      $display("FAIL b2b_throughput got last=%0d stalls=%0d want 9 0", last, stalled_in);
    end
  endtask

  task automatic test_random();
    int last;
    clear_vecs();
    for (int i = 0; i < 60; i++) add_vec(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    run_stream(0, 0, 1'b1, last);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0; op = 1'b0; sat = 1'b0;
    @(negedge clk);
    a = 8'h56; b = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rmid_inflight got out_valid=%b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async got valid=%b sum=%h cout=%b ovf=%b want 0", out_valid, sum, cout, ovf);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rmid_stale cycle=%0d got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

`ifdef CSEL_SAT_EN
  task automatic test_sat();
    logic [W+1:0] want [3] = '{{8'hFF, 1'b1, 1'b0}, {8'h00, 1'b0, 1'b0}, {8'h30, 1'b0, 1'b0}};
    int last;
    clear_vecs();
    add_vec(8'hF0, 8'h20, 1'b0, 1'b0, 1'b1);
    add_vec(8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
    add_vec(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    run_stream(0, 0, 1'b0, last);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== want[i]) begin
        bad++;
        $display("FAIL sat_vec%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, want[i]);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_add();
    test_sub();
    test_backpressure();
    test_back_to_back();
`ifdef CSEL_SAT_EN
    test_sat();
`endif
    test_random();
    test_reset_mid();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
